// File: rtl/beat_decoder.sv
// beat_decoder: receiving end of the 4-beat one-hot timing bus.
// Locks onto the T1..T4 rotation, emits one registered strobe per accepted
// beat (fetch/decode/exec/wb) and flags malformed or out-of-order beats.
// Optional feature: define BEAT_DECODER_STAT_EN to add the cycle_cnt port,
// a count of completed rotations (accepted T4 beats), modulo 2^CNT_W.

// One registered strobe per beat; high for exactly the cycle after 'set'.
module beat_decoder_strobe (
    input  logic clk,
    input  logic rst,
    input  logic set,
    output logic q
);
    // Strobe register, cleared by reset and by default every cycle
    always_ff @(posedge clk) begin
        if (rst) q <= 1'b0;
        else     q <= set;
    end
endmodule

module beat_decoder #(
    parameter bit RESYNC = 1'b1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       T,
    output logic             fetch,
    output logic             decode,
    output logic             exec,
    output logic             wb,
    output logic             sync,
    output logic             err,
    output logic [1:0]       err_code
`ifdef BEAT_DECODER_STAT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt
`endif
);
    typedef enum logic [1:0] {
        SYNC = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [3:0] BEAT_T1 = 4'b0001;
    localparam logic [3:0] BEAT_T2 = 4'b0010;
    localparam logic [1:0] CODE_NOT_ONEHOT = 2'b01;
    localparam logic [1:0] CODE_OUT_OF_SEQ = 2'b10;

    state_t     state_q, state_d;
    logic [3:0] exp_q, exp_d;
    logic       err_q, err_d;
    logic [1:0] code_q, code_d;
    logic       sync_q, sync_d;
    logic [3:0] stb_d;
    logic [3:0] stb_q;
    logic       t_onehot;

    // Exactly one bit set; 0000 counts as not one-hot
    assign t_onehot = (T != 4'b0000) && ((T & (T - 4'd1)) == 4'b0000);

    // State, expected-beat and sticky error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SYNC;
            exp_q   <= BEAT_T1;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
            sync_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            err_q   <= err_d;
            code_q  <= code_d;
            sync_q  <= sync_d;
        end
    end

    // Next-state logic: lock on T1, track the rotation, latch the first error
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        err_d   = err_q;
        code_d  = code_q;
        sync_d  = 1'b0;
        stb_d   = 4'b0000;
        case (state_q)
            SYNC: begin
                // Anything but T1 is ignored while hunting for the rotation
                if (T == BEAT_T1) begin
                    state_d = RUN;
                    exp_d   = BEAT_T2;
                    sync_d  = 1'b1;
                    stb_d   = BEAT_T1;
                end
            end
            RUN: begin
                if (T == exp_q) begin
                    stb_d  = T;
                    exp_d  = {exp_q[2:0], exp_q[3]};
                    sync_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                    // Only the first cause is kept; err_code stays put afterwards
                    if (!err_q)
                        code_d = t_onehot ? CODE_OUT_OF_SEQ : CODE_NOT_ONEHOT;
                    exp_d   = BEAT_T1;
                    state_d = RESYNC ? SYNC : ERR;
                end
            end
            ERR: begin
                // Parked until reset; bus is ignored
            end
            default: begin
                state_d = SYNC;
                exp_d   = BEAT_T1;
            end
        endcase
    end

    // One strobe register per beat position
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_stb
            beat_decoder_strobe u_stb (
                .clk (clk),
                .rst (rst),
                .set (stb_d[gi]),
                .q   (stb_q[gi])
            );
        end
    endgenerate

    assign fetch    = stb_q[0];
    assign decode   = stb_q[1];
    assign exec     = stb_q[2];
    assign wb       = stb_q[3];
    assign sync     = sync_q;
    assign err      = err_q;
    assign err_code = code_q;

`ifdef BEAT_DECODER_STAT_EN
    logic [CNT_W-1:0] cnt_q;

    // Rotation counter: bumps on the same edge that sets wb, holds otherwise
    always_ff @(posedge clk) begin
        if (rst)           cnt_q <= '0;
        else if (stb_d[3]) cnt_q <= cnt_q + CNT_W'(1);
    end

    assign cycle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_beat_decoder.sv
// Directed bench for beat_decoder. Two instances share clk/rst/T:
// 'da' relocks after errors (RESYNC=1, CNT_W=8), 'db' parks in ERR
// (RESYNC=0, CNT_W=2, so its counter wrap is visible).
module tb_beat_decoder;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] T;

    logic       a_fetch, a_decode, a_exec, a_wb, a_sync, a_err;
    logic [1:0] a_code;
    logic       b_fetch, b_decode, b_exec, b_wb, b_sync, b_err;
    logic [1:0] b_code;
`ifdef BEAT_DECODER_STAT_EN
    logic [7:0] a_cnt;
    logic [1:0] b_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    beat_decoder #(.RESYNC(1'b1), .CNT_W(8)) da (
        .clk(clk), .rst(rst), .T(T),
        .fetch(a_fetch), .decode(a_decode), .exec(a_exec), .wb(a_wb),
        .sync(a_sync), .err(a_err), .err_code(a_code)
`ifdef BEAT_DECODER_STAT_EN
        , .cycle_cnt(a_cnt)
`endif
    );

    beat_decoder #(.RESYNC(1'b0), .CNT_W(2)) db (
        .clk(clk), .rst(rst), .T(T),
        .fetch(b_fetch), .decode(b_decode), .exec(b_exec), .wb(b_wb),
        .sync(b_sync), .err(b_err), .err_code(b_code)
`ifdef BEAT_DECODER_STAT_EN
        , .cycle_cnt(b_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // stb is {wb,exec,decode,fetch}
    task automatic chk_a(input string tag, input logic [3:0] stb, input logic s,
                         input logic e, input logic [1:0] c);
        chk({tag, " a.stb"},  {4'b0, a_wb, a_exec, a_decode, a_fetch}, {4'b0, stb});
        chk({tag, " a.sync"}, {7'b0, a_sync}, {7'b0, s});
        chk({tag, " a.err"},  {7'b0, a_err},  {7'b0, e});
        chk({tag, " a.code"}, {6'b0, a_code}, {6'b0, c});
    endtask

    task automatic chk_b(input string tag, input logic [3:0] stb, input logic s,
                         input logic e, input logic [1:0] c);
        chk({tag, " b.stb"},  {4'b0, b_wb, b_exec, b_decode, b_fetch}, {4'b0, stb});
        chk({tag, " b.sync"}, {7'b0, b_sync}, {7'b0, s});
        chk({tag, " b.err"},  {7'b0, b_err},  {7'b0, e});
        chk({tag, " b.code"}, {6'b0, b_code}, {6'b0, c});
    endtask

    task automatic chk_cnt(input string tag, input logic [7:0] ea, input logic [1:0] eb);
`ifdef BEAT_DECODER_STAT_EN
        chk({tag, " a.cnt"}, a_cnt, ea);
        chk({tag, " b.cnt"}, {6'b0, b_cnt}, {6'b0, eb});
`endif
    endtask

    // Drive T clear of the edge, then sample 1 ns after the next rising edge
    task automatic step(input logic [3:0] t);
        T = t;
        @(posedge clk);
        #1;
    endtask

    // One clean rotation; both instances must be locked
    task automatic round(input string tag);
        step(4'b0001); chk_a({tag, " T1"}, 4'b0001, 1'b1, 1'b0, 2'b00); chk_b({tag, " T1"}, 4'b0001, 1'b1, 1'b0, 2'b00);
        step(4'b0010); chk_a({tag, " T2"}, 4'b0010, 1'b1, 1'b0, 2'b00); chk_b({tag, " T2"}, 4'b0010, 1'b1, 1'b0, 2'b00);
        step(4'b0100); chk_a({tag, " T3"}, 4'b0100, 1'b1, 1'b0, 2'b00); chk_b({tag, " T3"}, 4'b0100, 1'b1, 1'b0, 2'b00);
        step(4'b1000); chk_a({tag, " T4"}, 4'b1000, 1'b1, 1'b0, 2'b00); chk_b({tag, " T4"}, 4'b1000, 1'b1, 1'b0, 2'b00);
    endtask

    initial begin
        // Reset for the first cycle
        rst = 1'b1;
        T   = 4'b0000;
        @(posedge clk); #1;
        chk_a("reset", 4'b0000, 1'b0, 1'b0, 2'b00);
        chk_b("reset", 4'b0000, 1'b0, 1'b0, 2'b00);
        chk_cnt("reset", 8'd0, 2'd0);
        rst = 1'b0;

        // Hunting: non-T1 beats are ignored, no error
        step(4'b0100); chk_a("sync T3", 4'b0000, 1'b0, 1'b0, 2'b00);
        step(4'b1000); chk_a("sync T4", 4'b0000, 1'b0, 1'b0, 2'b00);
        step(4'b0000); chk_a("sync 0",  4'b0000, 1'b0, 1'b0, 2'b00);
        chk_b("sync 0", 4'b0000, 1'b0, 1'b0, 2'b00);

        // Three clean rounds, including the 1000 -> 0001 wrap
        round("r1"); chk_cnt("r1", 8'd1, 2'd1);
        round("r2"); chk_cnt("r2", 8'd2, 2'd2);
        round("r3"); chk_cnt("r3", 8'd3, 2'd3);
        // Two more: the 2-bit counter wraps 3 -> 0 -> 1
        round("r4"); chk_cnt("r4", 8'd4, 2'd0);
        round("r5"); chk_cnt("r5", 8'd5, 2'd1);

        // Locked, then a non-one-hot beat
        step(4'b0110);
        chk_a("bad 0110", 4'b0000, 1'b0, 1'b1, 2'b01);
        chk_b("bad 0110", 4'b0000, 1'b0, 1'b1, 2'b01);
        chk_cnt("bad 0110", 8'd5, 2'd1);
        // RESYNC=1 relocks with err still set; RESYNC=0 stays parked
        step(4'b0001);
        chk_a("relock T1", 4'b0001, 1'b1, 1'b1, 2'b01);
        chk_b("parked T1", 4'b0000, 1'b0, 1'b1, 2'b01);
        step(4'b0010);
        chk_a("relock T2", 4'b0010, 1'b1, 1'b1, 2'b01);
        chk_b("parked T2", 4'b0000, 1'b0, 1'b1, 2'b01);

        // Reset mid-rotation wins over the beat
        step(4'b0100);
        chk_a("pre-rst T3", 4'b0100, 1'b1, 1'b1, 2'b01);
        rst = 1'b1;
        step(4'b0100);
        chk_a("rst mid", 4'b0000, 1'b0, 1'b0, 2'b00);
        chk_b("rst mid", 4'b0000, 1'b0, 1'b0, 2'b00);
        chk_cnt("rst mid", 8'd0, 2'd0);
        rst = 1'b0;
        step(4'b0010); chk_a("post-rst T2", 4'b0000, 1'b0, 1'b0, 2'b00);
        step(4'b0001);
        chk_a("post-rst T1", 4'b0001, 1'b1, 1'b0, 2'b00);
        chk_b("post-rst T1", 4'b0001, 1'b1, 1'b0, 2'b00);

        // One-hot but out of order
        step(4'b0100);
        chk_a("seq 0100", 4'b0000, 1'b0, 1'b1, 2'b10);
        chk_b("seq 0100", 4'b0000, 1'b0, 1'b1, 2'b10);
        // Relock, then a second (different-cause) error keeps the first code
        step(4'b0001);
        chk_a("seq relock", 4'b0001, 1'b1, 1'b1, 2'b10);
        chk_b("seq parked", 4'b0000, 1'b0, 1'b1, 2'b10);
        step(4'b0000);
        chk_a("2nd err", 4'b0000, 1'b0, 1'b1, 2'b10);
        chk_b("2nd err", 4'b0000, 1'b0, 1'b1, 2'b10);
        // Parked instance ignores a further valid rotation
        step(4'b0001);
        chk_b("parked r T1", 4'b0000, 1'b0, 1'b1, 2'b10);
        chk_a("resync T1",   4'b0001, 1'b1, 1'b1, 2'b10);
        step(4'b0010);
        chk_b("parked r T2", 4'b0000, 1'b0, 1'b1, 2'b10);
        step(4'b0100);
        chk_b("parked r T3", 4'b0000, 1'b0, 1'b1, 2'b10);
        step(4'b1000);
        chk_b("parked r T4", 4'b0000, 1'b0, 1'b1, 2'b10);
        chk_a("resync T4",   4'b1000, 1'b1, 1'b1, 2'b10);
        chk_cnt("after errs", 8'd1, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
